// File: rtl/pipelined_remultiplier_if.sv
// Operand/result bundle for pipelined_remultiplier: tagged (q, d, r) in, tagged q*d+r out.
interface pipelined_remultiplier_if #(
    parameter int dividend_width = 32,
    parameter int divisor_width  = 24,
    parameter int tag_width      = 6
);
    localparam int product_width = dividend_width + divisor_width + 1;

    // input_valid qualifies input_tag/quotient/divisor/remainder on every rising edge; there is
    // no ready, so every valid cycle is accepted. output_valid qualifies output_tag/product for
    // exactly one cycle and cannot be stalled.
    logic                      input_valid;
    logic [tag_width-1:0]      input_tag;
    logic [dividend_width-1:0] quotient;
    logic [divisor_width-1:0]  divisor;
    logic [dividend_width-1:0] remainder;
    logic                      output_valid;
    logic [tag_width-1:0]      output_tag;
    logic [product_width-1:0]  product;

    modport master (
        output input_valid, input_tag, quotient, divisor, remainder,
        input  output_valid, output_tag, product
    );

    modport slave (
        input  input_valid, input_tag, quotient, divisor, remainder,
        output output_valid, output_tag, product
    );
endinterface

// File: rtl/pipelined_remultiplier.sv
// Shift-add pipeline rebuilding dividend = quotient*divisor + remainder, one quotient bit per stage.
module pipelined_remultiplier #(
    parameter int dividend_width = 32,
    parameter int divisor_width  = 24,
    parameter int tag_width      = 6
) (
    input logic                    clock,
    input logic                    reset_n,
    pipelined_remultiplier_if.slave bus
);
    localparam int stages        = dividend_width;
    localparam int product_width = dividend_width + divisor_width + 1;

    // Index 0 is the load register; index i+1 holds the accumulator after quotient bit i.
    logic                     stage_valid [0:stages];
    logic [tag_width-1:0]     stage_tag   [0:stages];
    logic [product_width-1:0] stage_acc   [0:stages];
    logic [divisor_width-1:0] stage_d     [0:stages-1];
    logic [dividend_width-1:0] stage_q    [0:stages-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_valid[0] <= 1'b0;
            stage_tag[0]   <= '0;
            stage_acc[0]   <= '0;
            stage_d[0]     <= '0;
            stage_q[0]     <= '0;
        end else begin
            stage_valid[0] <= bus.input_valid;
            stage_tag[0]   <= bus.input_tag;
            stage_acc[0]   <= {{(product_width-dividend_width){bus.remainder[dividend_width-1]}},
                               bus.remainder};
            stage_d[0]     <= bus.divisor;
            stage_q[0]     <= bus.quotient;
        end
    end

    for (genvar i = 0; i < stages; i++) begin : g_stage
        logic [product_width-1:0] weight;
        logic [product_width-1:0] next_acc;

        // The quotient is shifted right each stage, so bit 0 is always bit i of the original.
        // The top bit carries negative weight in two's complement, hence the subtraction.
        always_comb begin
            weight   = {{(product_width-divisor_width){1'b0}}, stage_d[i]} << i;
            next_acc = stage_acc[i];
            if (stage_q[i][0]) begin
                if (i == stages - 1) begin
                    next_acc = stage_acc[i] - weight;
                end else begin
                    next_acc = stage_acc[i] + weight;
                end
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                stage_valid[i+1] <= 1'b0;
                stage_tag[i+1]   <= '0;
                stage_acc[i+1]   <= '0;
            end else begin
                stage_valid[i+1] <= stage_valid[i];
                stage_tag[i+1]   <= stage_tag[i];
                stage_acc[i+1]   <= next_acc;
            end
        end

        if (i < stages - 1) begin : g_fwd
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    stage_d[i+1] <= '0;
                    stage_q[i+1] <= '0;
                end else begin
                    stage_d[i+1] <= stage_d[i];
                    stage_q[i+1] <= stage_q[i] >> 1;
                end
            end
        end
    end

    assign bus.output_valid = stage_valid[stages];
    assign bus.output_tag   = stage_tag[stages];
    assign bus.product      = stage_acc[stages];
endmodule

// File: tb/tb_pipelined_remultiplier.sv
// Directed and random checks of pipelined_remultiplier against an arithmetic q*d+r model.
module tb_pipelined_remultiplier;
    localparam int DW     = 32;
    localparam int VW     = 24;
    localparam int TW     = 6;
    localparam int STAGES = DW;
    localparam int PW     = DW + VW + 1;
    localparam int EW     = 1 + TW + PW;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    pipelined_remultiplier_if #(.dividend_width(DW), .divisor_width(VW), .tag_width(TW)) bus ();

    pipelined_remultiplier #(.dividend_width(DW), .divisor_width(VW), .tag_width(TW)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    // One entry per sampling edge: {valid, tag, product}; depth STAGES models the latency.
    logic [EW-1:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;

    function automatic logic [PW-1:0] golden(logic [DW-1:0] q, logic [VW-1:0] d, logic [DW-1:0] r);
        longint p;
        p = longint'($signed(q)) * longint'(d) + longint'($signed(r));
        return p[PW-1:0];
    endfunction

    task automatic check(string name, logic [63:0] observed, logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    task automatic refill();
        exp_q.delete();
        repeat (STAGES) exp_q.push_back('0);
    endtask

    task automatic check_zero(string name);
        check({name, "_valid"}, 64'(bus.output_valid), 64'd0);
        check({name, "_tag"}, 64'(bus.output_tag), 64'd0);
        check({name, "_product"}, 64'(bus.product), 64'd0);
    endtask

    // Drive one cycle, then compare the output produced by that edge with the model.
    task automatic step(logic v, logic [TW-1:0] tag, logic [DW-1:0] q, logic [VW-1:0] d,
                        logic [DW-1:0] r, logic [PW-1:0] exp_p);
        logic [EW-1:0] e;
        bus.input_valid = v;
        bus.input_tag   = tag;
        bus.quotient    = q;
        bus.divisor     = d;
        bus.remainder   = r;
        @(posedge clock);
        exp_q.push_back({v, tag, exp_p});
        e = exp_q.pop_front();
        #1;
        check("output_valid", 64'(bus.output_valid), 64'(e[EW-1]));
        if (e[EW-1]) begin
            check("output_tag", 64'(bus.output_tag), 64'(e[PW +: TW]));
            check("product", 64'(bus.product), 64'(e[PW-1:0]));
        end
    endtask

    task automatic op(logic [TW-1:0] tag, logic [DW-1:0] q, logic [VW-1:0] d, logic [DW-1:0] r);
        step(1'b1, tag, q, d, r, golden(q, d, r));
    endtask

    task automatic bubble(logic [TW-1:0] tag, logic [DW-1:0] q, logic [VW-1:0] d, logic [DW-1:0] r);
        step(1'b0, tag, q, d, r, golden(q, d, r));
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, '0, '0, '0, '0, '0);
    endtask

    task automatic rand_op(logic [TW-1:0] tag);
        op(tag, DW'($urandom()), VW'($urandom()), DW'($urandom()));
    endtask

    initial begin
        longint dv, dd;
        logic [DW-1:0] dividend, qq, rr;
        logic [VW-1:0] dsr;

        // Clock/reset
        reset_n         = 1'b0;
        bus.input_valid = 1'b0;
        bus.input_tag   = '0;
        bus.quotient    = '0;
        bus.divisor     = '0;
        bus.remainder   = '0;
        #1;
        check_zero("reset");
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        refill();

        // Basic, signed and extreme operands, each followed by a full drain
        op(6'd5, 32'd7, 24'd3, 32'd2);
        idle(STAGES + 2);
        op(6'd9, -32'sd7, 24'd3, -32'sd2);
        idle(STAGES + 2);
        op(6'd1, 32'h8000_0000, 24'hFF_FFFF, 32'h8000_0000);
        op(6'd2, DW'($urandom()), 24'd0, 32'hFFFF_FFFF);
        op(6'd3, 32'h7FFF_FFFF, 24'hFF_FFFF, 32'h7FFF_FFFF);
        op(6'd4, 32'hFFFF_FFFF, 24'hFF_FFFF, 32'd0);
        idle(STAGES + 2);

        // 64 back-to-back random ops
        for (int i = 0; i < 64; i++) rand_op(TW'(i));
        idle(STAGES + 2);

        // Bubble pattern 1,0,0,1,1
        rand_op(6'd10);
        bubble(6'd11, DW'($urandom()), VW'($urandom()), DW'($urandom()));
        bubble(6'd12, DW'($urandom()), VW'($urandom()), DW'($urandom()));
        rand_op(6'd13);
        rand_op(6'd14);
        idle(STAGES + 2);

        // Random valid pattern, then reset while the pipeline is full
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) rand_op(TW'(i));
            else idle(1);
        end
        for (int i = 0; i < 20; i++) rand_op(TW'(i));
        #3;
        reset_n = 1'b0;
        #1;
        check_zero("reset_mid");
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset_hold");
        @(negedge clock);
        reset_n = 1'b1;
        refill();
        idle(STAGES + 2);
        for (int i = 0; i < 8; i++) rand_op(TW'(i + 20));
        idle(STAGES + 2);

        // Loopback: a software divider produces (q, r); the product must be the dividend
        for (int i = 0; i < 500; i++) begin
            dividend = DW'($urandom());
            if (i == 0) dividend = 32'h8000_0000;
            dsr = VW'($urandom_range(1, (1 << VW) - 1));
            if (i == 1) dsr = 24'hFF_FFFF;
            dv = longint'($signed(dividend));
            dd = longint'(dsr);
            qq = DW'(dv / dd);
            rr = DW'(dv % dd);
            step(1'b1, TW'(i), qq, dsr, rr, {{(PW-DW){dividend[DW-1]}}, dividend});
        end
        idle(STAGES + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
